// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared digit code layout and display arbitration state
package seg_pkg;
    localparam int SEG_EN = 5;
    localparam int SEG_DP = 4;

    typedef struct packed {
        logic       en;
        logic       dp;
        logic [3:0] nibble;
    } seg_code_t;

    typedef enum logic {
        SHOW_BASE    = 1'b0,
        SHOW_OVERLAY = 1'b1
    } disp_state_t;
endpackage

// File: rtl/seg_update_slot.sv
// rtl/seg_update_slot.sv - one-entry pending/active register committed on frame boundaries
module seg_update_slot #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             valid,
    output logic             ready,
    input  logic [WIDTH-1:0] payload,
    input  logic             frame_boundary,
    output logic             commit,
    output logic [WIDTH-1:0] active
);
    logic             pending;
    logic [WIDTH-1:0] held;

    assign commit = frame_boundary && pending;

    // ready is low exactly while an update is waiting for its boundary
    always_ff @(posedge clock) begin
        if (reset) begin
            pending <= 1'b0;
            ready   <= 1'b0;
            held    <= '0;
            active  <= '0;
        end else if (valid && ready) begin
            held    <= payload;
            pending <= 1'b1;
            ready   <= 1'b0;
        end else if (commit) begin
            active  <= held;
            pending <= 1'b0;
            ready   <= 1'b1;
        end else begin
            ready   <= !pending;
        end
    end
endmodule

// File: rtl/segment_display_controller.sv
// rtl/segment_display_controller.sv - scan sequencer and base/overlay arbiter for a multi-digit display
module segment_display_controller #(
    parameter int NUMBER_OF_DIGITS = 6,
    parameter int SCAN_DIVIDER     = 1000,
    parameter int BLINK_FRAMES     = 64,
    parameter int OVERLAY_FRAMES   = 500
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          base_valid,
    output logic                          base_ready,
    input  logic [4*NUMBER_OF_DIGITS-1:0] base_value,
    input  logic [NUMBER_OF_DIGITS-1:0]   base_dp,
    input  logic                          base_lz_blank,
    input  logic [NUMBER_OF_DIGITS-1:0]   blink_mask,
    input  logic                          ovl_valid,
    output logic                          ovl_ready,
    input  logic [4*NUMBER_OF_DIGITS-1:0] ovl_value,
    input  logic [NUMBER_OF_DIGITS-1:0]   ovl_dp,
    output logic                          next_segment,
    output logic [5:0]                    digits [0:NUMBER_OF_DIGITS-1],
    output logic                          overlay_active
);
    import seg_pkg::*;

    localparam int N       = NUMBER_OF_DIGITS;
    localparam int SCAN_W  = $clog2(SCAN_DIVIDER);
    localparam int IDX_W   = (N > 1) ? $clog2(N) : 1;
    localparam int BLINK_W = $clog2(BLINK_FRAMES + 1);
    localparam int HOLD_W  = $clog2(OVERLAY_FRAMES + 1);
    localparam int BASE_W  = 5 * N + 1;
    localparam int OVL_W   = 5 * N;

    logic [SCAN_W-1:0]  scan_cnt;
    logic [IDX_W-1:0]   digit_idx;
    logic [BLINK_W-1:0] blink_cnt;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic               blink_phase;
    logic               started;
    logic               scan_tick;
    logic               frame_boundary;
    disp_state_t        state_q, state_d;

    logic [BASE_W-1:0]  base_active;
    logic [OVL_W-1:0]   ovl_active;
    logic               base_commit_unused;
    logic               ovl_commit;

    assign scan_tick      = (scan_cnt == SCAN_W'(SCAN_DIVIDER - 1));
    assign frame_boundary = scan_tick && (digit_idx == IDX_W'(N - 1));
    assign overlay_active = (state_q == SHOW_OVERLAY);

    // Top bit stores "keep leading zeros" so the reset value of the slot means blanking on
    seg_update_slot #(.WIDTH(BASE_W)) u_base_slot (
        .clock          (clock),
        .reset          (reset),
        .valid          (base_valid),
        .ready          (base_ready),
        .payload        ({~base_lz_blank, base_dp, base_value}),
        .frame_boundary (frame_boundary),
        .commit         (base_commit_unused),
        .active         (base_active)
    );

    seg_update_slot #(.WIDTH(OVL_W)) u_ovl_slot (
        .clock          (clock),
        .reset          (reset),
        .valid          (ovl_valid),
        .ready          (ovl_ready),
        .payload        ({ovl_dp, ovl_value}),
        .frame_boundary (frame_boundary),
        .commit         (ovl_commit),
        .active         (ovl_active)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            scan_cnt     <= '0;
            next_segment <= 1'b0;
            digit_idx    <= '0;
            blink_cnt    <= '0;
            blink_phase  <= 1'b0;
            started      <= 1'b0;
            state_q      <= SHOW_BASE;
            hold_q       <= '0;
        end else begin
            next_segment <= scan_tick;
            scan_cnt     <= scan_tick ? '0 : scan_cnt + SCAN_W'(1);
            if (scan_tick) begin
                digit_idx <= frame_boundary ? '0 : digit_idx + IDX_W'(1);
            end
            if (frame_boundary) begin
                started <= 1'b1;
                if (blink_cnt == BLINK_W'(BLINK_FRAMES - 1)) begin
                    blink_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    blink_cnt <= blink_cnt + BLINK_W'(1);
                end
            end
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    // An overlay commit always (re)loads the hold; otherwise count down frames while shown
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        if (ovl_commit) begin
            state_d = SHOW_OVERLAY;
            hold_d  = HOLD_W'(OVERLAY_FRAMES);
        end else if (state_q == SHOW_OVERLAY && frame_boundary) begin
            hold_d = hold_q - HOLD_W'(1);
            if (hold_q == HOLD_W'(1)) begin
                state_d = SHOW_BASE;
            end
        end
    end

    seg_code_t code_d [0:N-1];
    logic      leading;
    logic      blanked;

    always_comb begin
        leading = !base_active[BASE_W-1];
        blanked = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            code_d[i] = '0;
            if (state_q == SHOW_OVERLAY) begin
                code_d[i].en     = 1'b1;
                code_d[i].dp     = ovl_active[4*N + i];
                code_d[i].nibble = ovl_active[4*i +: 4];
            end else begin
                code_d[i].dp     = base_active[4*N + i];
                code_d[i].nibble = base_active[4*i +: 4];
                blanked = leading && (i != 0) && (code_d[i].nibble == 4'h0) && !code_d[i].dp;
                leading = blanked;
                code_d[i].en = !blanked && !(blink_mask[i] && blink_phase);
            end
            if (!started) begin
                code_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < N; i++) begin
            digits[i] <= reset ? 6'h00 : code_d[i];
        end
    end
endmodule

// File: tb/tb_segment_display_controller.sv
// tb/tb_segment_display_controller.sv - directed self-checking bench for segment_display_controller
module tb_segment_display_controller;
    localparam int N  = 6;
    localparam int SD = 4;
    localparam int BF = 2;
    localparam int OF = 3;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic           base_valid = 1'b0;
    logic           base_ready;
    logic [4*N-1:0] base_value = '0;
    logic [N-1:0]   base_dp = '0;
    logic           base_lz_blank = 1'b0;
    logic [N-1:0]   blink_mask = '0;
    logic           ovl_valid = 1'b0;
    logic           ovl_ready;
    logic [4*N-1:0] ovl_value = '0;
    logic [N-1:0]   ovl_dp = '0;
    logic           next_segment;
    logic [5:0]     digits [0:N-1];
    logic           overlay_active;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [5:0] exp [0:N-1];

    segment_display_controller #(
        .NUMBER_OF_DIGITS (N),
        .SCAN_DIVIDER     (SD),
        .BLINK_FRAMES     (BF),
        .OVERLAY_FRAMES   (OF)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .base_valid     (base_valid),
        .base_ready     (base_ready),
        .base_value     (base_value),
        .base_dp        (base_dp),
        .base_lz_blank  (base_lz_blank),
        .blink_mask     (blink_mask),
        .ovl_valid      (ovl_valid),
        .ovl_ready      (ovl_ready),
        .ovl_value      (ovl_value),
        .ovl_dp         (ovl_dp),
        .next_segment   (next_segment),
        .digits         (digits),
        .overlay_active (overlay_active)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int target);
        while (cyc < target) step();
    endtask

    task automatic test_reset();
        step();
        step();
        total++;
        if ({base_ready, ovl_ready, next_segment, overlay_active} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_ctrl: got %b want 0000 (base_ready ovl_ready next_segment overlay_active)",
                     {base_ready, ovl_ready, next_segment, overlay_active});
        end
        for (int i = 0; i < N; i++) begin
            total++;
            if (digits[i] !== 6'h00) begin
                bad++;
                $display("FAIL reset_digit%0d: got %h want 00", i, digits[i]);
            end
        end
        reset = 1'b0;
        cyc = 0;
        step();
        total++;
        if ({base_ready, ovl_ready} !== 2'b11) begin
            bad++;
            $display("FAIL ready_after_release: got %b want 11", {base_ready, ovl_ready});
        end
    endtask

    task automatic test_scan();
        while (cyc < 25) begin
            step();
            total++;
            if (next_segment !== (cyc % SD == 0)) begin
                bad++;
                $display("FAIL scan_strobe@%0d: got %b want %b", cyc, next_segment, (cyc % SD == 0));
            end
            if (cyc <= 24) begin
                for (int i = 0; i < N; i++) begin
                    total++;
                    if (digits[i] !== 6'h00) begin
                        bad++;
                        $display("FAIL idle_blank@%0d digit%0d: got %h want 00", cyc, i, digits[i]);
                    end
                end
            end
        end
        exp = '{6'h20, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};
        for (int i = 0; i < N; i++) begin
            total++;
            if (digits[i] !== exp[i]) begin
                bad++;
                $display("FAIL first_frame digit%0d: got %h want %h", i, digits[i], exp[i]);
            end
        end
    endtask

    task automatic test_lz_blank();
        run_to(30);
        base_valid = 1'b1;
        base_value = 24'h000120;
        base_dp = '0;
        base_lz_blank = 1'b1;
        step();
        base_valid = 1'b0;
        base_value = 24'hFFFFFF;
        total++;
        if (base_ready !== 1'b0) begin
            bad++;
            $display("FAIL lz_ready_drop: got %b want 0", base_ready);
        end
        run_to(47);
        total++;
        if (base_ready !== 1'b0) begin
            bad++;
            $display("FAIL lz_ready_before_commit: got %b want 0", base_ready);
        end
        step();
        total++;
        if (base_ready !== 1'b1) begin
            bad++;
            $display("FAIL lz_ready_after_commit: got %b want 1", base_ready);
        end
        step();
        exp = '{6'h20, 6'h22, 6'h21, 6'h00, 6'h00, 6'h00};
        for (int i = 0; i < N; i++) begin
            total++;
            if (digits[i] !== exp[i]) begin
                bad++;
                $display("FAIL lz_digits digit%0d: got %h want %h", i, digits[i], exp[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        run_to(50);
        base_valid = 1'b1;
        base_value = 24'h000345;
        base_lz_blank = 1'b0;
        step();
        base_value = 24'h000999;
        step();
        total++;
        if (base_ready !== 1'b0) begin
            bad++;
            $display("FAIL b2b_second_blocked: got %b want 0", base_ready);
        end
        step();
        base_valid = 1'b0;
        run_to(73);
        exp = '{6'h25, 6'h24, 6'h23, 6'h20, 6'h20, 6'h20};
        for (int i = 0; i < N; i++) begin
            total++;
            if (digits[i] !== exp[i]) begin
                bad++;
                $display("FAIL b2b_first_shown digit%0d: got %h want %h", i, digits[i], exp[i]);
            end
        end
        base_valid = 1'b1;
        step();
        base_valid = 1'b0;
        total++;
        if (base_ready !== 1'b0) begin
            bad++;
            $display("FAIL b2b_retry_accepted: got %b want 0", base_ready);
        end
        run_to(95);
        total++;
        if (digits[0] !== 6'h25) begin
            bad++;
            $display("FAIL b2b_retry_early: got %h want 25", digits[0]);
        end
        run_to(97);
        exp = '{6'h29, 6'h29, 6'h29, 6'h20, 6'h20, 6'h20};
        for (int i = 0; i < N; i++) begin
            total++;
            if (digits[i] !== exp[i]) begin
                bad++;
                $display("FAIL b2b_retry_shown digit%0d: got %h want %h", i, digits[i], exp[i]);
            end
        end
    endtask

    task automatic test_overlay();
        ovl_valid = 1'b1;
        ovl_value = 24'hABCDEF;
        ovl_dp = '0;
        step();
        ovl_valid = 1'b0;
        ovl_value = 24'h000000;
        total++;
        if (ovl_ready !== 1'b0) begin
            bad++;
            $display("FAIL ovl_ready_drop: got %b want 0", ovl_ready);
        end
        run_to(119);
        total++;
        if (overlay_active !== 1'b0) begin
            bad++;
            $display("FAIL ovl_early: got %b want 0", overlay_active);
        end
        step();
        total++;
        if (overlay_active !== 1'b1) begin
            bad++;
            $display("FAIL ovl_rise: got %b want 1", overlay_active);
        end
        step();
        exp = '{6'h2F, 6'h2E, 6'h2D, 6'h2C, 6'h2B, 6'h2A};
        for (int i = 0; i < N; i++) begin
            total++;
            if (digits[i] !== exp[i]) begin
                bad++;
                $display("FAIL ovl_digits digit%0d: got %h want %h", i, digits[i], exp[i]);
            end
        end
        blink_mask = 6'b000001;
        base_valid = 1'b1;
        base_value = 24'h000042;
        base_lz_blank = 1'b1;
        step();
        base_valid = 1'b0;
        run_to(150);
        total++;
        if ({overlay_active, digits[0]} !== {1'b1, 6'h2F}) begin
            bad++;
            $display("FAIL ovl_ignores_blink: got %b/%h want 1/2f", overlay_active, digits[0]);
        end
        run_to(191);
        total++;
        if (overlay_active !== 1'b1) begin
            bad++;
            $display("FAIL ovl_hold: got %b want 1", overlay_active);
        end
        step();
        total++;
        if (overlay_active !== 1'b0) begin
            bad++;
            $display("FAIL ovl_fall: got %b want 0", overlay_active);
        end
        step();
        exp = '{6'h22, 6'h24, 6'h00, 6'h00, 6'h00, 6'h00};
        for (int i = 0; i < N; i++) begin
            total++;
            if (digits[i] !== exp[i]) begin
                bad++;
                $display("FAIL ovl_restore digit%0d: got %h want %h", i, digits[i], exp[i]);
            end
        end
    endtask

    task automatic test_blink();
        logic [5:0] want [0:3];
        int         at [0:3];
        want = '{6'h22, 6'h02, 6'h02, 6'h22};
        at   = '{239, 241, 287, 289};
        for (int k = 0; k < 4; k++) begin
            run_to(at[k]);
            total++;
            if ({digits[1], digits[0]} !== {6'h24, want[k]}) begin
                bad++;
                $display("FAIL blink@%0d: got %h/%h want 24/%h", cyc, digits[1], digits[0], want[k]);
            end
        end
    endtask

    task automatic test_reset_mid();
        run_to(290);
        blink_mask = '0;
        ovl_valid = 1'b1;
        ovl_value = 24'h123456;
        base_valid = 1'b1;
        base_value = 24'h777777;
        base_lz_blank = 1'b0;
        step();
        ovl_valid = 1'b0;
        base_valid = 1'b0;
        total++;
        if ({base_ready, ovl_ready} !== 2'b00) begin
            bad++;
            $display("FAIL mid_pending: got %b want 00", {base_ready, ovl_ready});
        end
        reset = 1'b1;
        step();
        total++;
        if ({base_ready, ovl_ready, overlay_active, next_segment} !== 4'b0000) begin
            bad++;
            $display("FAIL mid_reset_ctrl: got %b want 0000", {base_ready, ovl_ready, overlay_active, next_segment});
        end
        for (int i = 0; i < N; i++) begin
            total++;
            if (digits[i] !== 6'h00) begin
                bad++;
                $display("FAIL mid_reset digit%0d: got %h want 00", i, digits[i]);
            end
        end
        step();
        reset = 1'b0;
        cyc = 0;
        step();
        total++;
        if ({base_ready, ovl_ready} !== 2'b11) begin
            bad++;
            $display("FAIL mid_release_ready: got %b want 11", {base_ready, ovl_ready});
        end
        exp = '{6'h20, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};
        for (int t = 25; t <= 50; t += 25) begin
            run_to(t);
            total++;
            if (overlay_active !== 1'b0) begin
                bad++;
                $display("FAIL mid_stale_ovl@%0d: got %b want 0", cyc, overlay_active);
            end
            for (int i = 0; i < N; i++) begin
                total++;
                if (digits[i] !== exp[i]) begin
                    bad++;
                    $display("FAIL mid_stale@%0d digit%0d: got %h want %h", cyc, i, digits[i], exp[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_lz_blank();
        test_back_to_back();
        test_overlay();
        test_blink();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
